// File: rtl/local_ctrl_layer2.sv
// Layer-2 fully-connected controller for the MNIST streamline.
// Sweeps the hidden-activation buffer once per output neuron, addresses the
// weight ROM in lockstep, drives the shared MAC and commits each score.
// Build option: define LAYER2_RELU_EN to request ReLU on each committed score;
// otherwise relu_en_o is tied low (raw logits). Cycle timing is identical.
module local_ctrl_layer2 #(
    parameter int unsigned NUM_IN  = 128,
    parameter int unsigned NUM_OUT = 10,
    parameter int unsigned DRAIN   = 4,
    parameter int unsigned X_AW    = 7,
    parameter int unsigned W_AW    = 11
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    output logic [X_AW-1:0] x_addr_o,
    output logic [W_AW-1:0] w_addr_o,
    output logic            rd_en_o,
    output logic            mac_en_o,
    output logic            acc_clr_o,
    output logic            relu_en_o,
    output logic [3:0]      out_addr_o,
    output logic            out_wr_en_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StSave,
        StNext,
        StDone
    } state_e;

    state_e          state_q, state_d;
    // cnt is shared: operand index in RUN, drain cycle index in DRAIN
    logic [X_AW-1:0] cnt_q, cnt_d;
    logic [3:0]      n_q, n_d;
    logic            mac_q;
    logic            rd_en;

    // State, counters and the one-cycle read-latency delay for mac_en
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            n_q     <= '0;
            mac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            mac_q   <= rd_en;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    n_d     = '0;
                end
            end
            StRun: begin
                if (cnt_q == X_AW'(NUM_IN - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + X_AW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == X_AW'(DRAIN - 1)) begin
                    state_d = StSave;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + X_AW'(1);
                end
            end
            StSave: begin
                state_d = StNext;
            end
            StNext: begin
                if (n_q == 4'(NUM_OUT - 1)) begin
                    state_d = StDone;
                end else begin
                    n_d     = n_q + 4'(1);
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                n_d     = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from the registered state and counters
    always_comb begin
        rd_en       = (state_q == StRun);
        rd_en_o     = rd_en;
        x_addr_o    = rd_en ? cnt_q : '0;
        w_addr_o    = rd_en ? (W_AW'(n_q) * W_AW'(NUM_IN) + W_AW'(cnt_q)) : '0;
        mac_en_o    = mac_q;
        // First RUN cycle of neuron 0 clears the accumulator left by any prior run
        acc_clr_o   = (state_q == StNext) ||
                      ((state_q == StRun) && (n_q == '0) && (cnt_q == '0));
        out_wr_en_o = (state_q == StSave);
        out_addr_o  = (state_q == StSave) ? n_q : '0;
`ifdef LAYER2_RELU_EN
        relu_en_o   = (state_q == StSave);
`else
        relu_en_o   = 1'b0;
`endif
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
    end

endmodule

// File: tb/tb_local_ctrl_layer2.sv
// Directed bench for local_ctrl_layer2: default-size and reduced-size instances.
module tb_local_ctrl_layer2;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        start_s;

    logic [6:0]  x_addr;
    logic [10:0] w_addr;
    logic        rd_en, mac_en, acc_clr, relu_en, out_wr_en, busy, done;
    logic [3:0]  out_addr;

    logic [1:0]  s_x_addr;
    logic [2:0]  s_w_addr;
    logic        s_rd_en, s_mac_en, s_acc_clr, s_relu_en, s_out_wr_en, s_busy, s_done;
    logic [3:0]  s_out_addr;

    int checks;
    int failures;

    local_ctrl_layer2 u_dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .x_addr_o    (x_addr),
        .w_addr_o    (w_addr),
        .rd_en_o     (rd_en),
        .mac_en_o    (mac_en),
        .acc_clr_o   (acc_clr),
        .relu_en_o   (relu_en),
        .out_addr_o  (out_addr),
        .out_wr_en_o (out_wr_en),
        .busy_o      (busy),
        .done_o      (done)
    );

    local_ctrl_layer2 #(
        .NUM_IN  (4),
        .NUM_OUT (2),
        .DRAIN   (1),
        .X_AW    (2),
        .W_AW    (3)
    ) u_small (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start_s),
        .x_addr_o    (s_x_addr),
        .w_addr_o    (s_w_addr),
        .rd_en_o     (s_rd_en),
        .mac_en_o    (s_mac_en),
        .acc_clr_o   (s_acc_clr),
        .relu_en_o   (s_relu_en),
        .out_addr_o  (s_out_addr),
        .out_wr_en_o (s_out_wr_en),
        .busy_o      (s_busy),
        .done_o      (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LAYER2_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    task automatic test_reset();
        logic [32:0] obs;
        rstn    = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {x_addr, w_addr, rd_en, mac_en, acc_clr, relu_en, out_addr, out_wr_en, busy, done};
        checks++;
        if (obs !== 33'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, rd_en, done, s_busy} !== 4'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%b want=0000", k,
                         {busy, rd_en, done, s_busy});
            end
        end
    endtask

    // Caller drives start=1 at a negedge; the next posedge samples it (cycle 0).
    // start is re-pulsed during cycles 5, 700 and the done cycle; all must be ignored.
    task automatic test_full_run(input int run_id);
        logic [28:0] exp_v, obs_v;
        logic        e_rd, e_mac, e_clr, e_wr, e_done, e_relu;
        logic [6:0]  e_x;
        logic [10:0] e_w;
        logic [3:0]  e_oa;
        int          n, off, wr_cnt, clr_cnt, done_cnt;
        wr_cnt   = 0;
        clr_cnt  = 0;
        done_cnt = 0;
        @(posedge clk);
        for (int k = 1; k <= 1341; k++) begin
            @(negedge clk);
            start  = (k == 5) || (k == 700) || (k == 1341);
            n      = (k - 1) / 134;
            off    = (k - 1) % 134;
            e_done = (k == 1341);
            e_rd   = !e_done && (off < 128);
            e_mac  = !e_done && (off >= 1) && (off <= 128);
            e_wr   = !e_done && (off == 132);
            e_clr  = !e_done && ((off == 133) || (k == 1));
            e_relu = RELU && e_wr;
            e_x    = e_rd ? 7'(off) : 7'd0;
            e_w    = e_rd ? 11'(n * 128 + off) : 11'd0;
            e_oa   = (e_wr || e_done) ? 4'(n) : 4'd0;
            if (e_done) e_oa = 4'd0;
            exp_v  = {1'b1, e_rd, e_mac, e_clr, e_wr, e_done, e_relu, e_x, e_w, e_oa};
            obs_v  = {busy, rd_en, mac_en, acc_clr, out_wr_en, done, relu_en,
                      e_rd ? x_addr : 7'd0, e_rd ? w_addr : 11'd0,
                      (e_wr || e_done) ? out_addr : 4'd0};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL full_run%0d cycle=%0d got=%h want=%h", run_id, k, obs_v, exp_v);
            end
            if (out_wr_en === 1'b1) wr_cnt++;
            if (acc_clr === 1'b1) clr_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (wr_cnt != 10) begin
            failures++;
            $display("FAIL full_run%0d_wr_count got=%0d want=10", run_id, wr_cnt);
        end
        checks++;
        if (clr_cnt != 11) begin
            failures++;
            $display("FAIL full_run%0d_clr_count got=%0d want=11", run_id, clr_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL full_run%0d_done_count got=%0d want=1", run_id, done_cnt);
        end
    endtask

    // start sampled on the done cycle is ignored; the IDLE cycle after it launches run 2
    task automatic test_back_to_back();
        @(negedge clk);
        checks++;
        if ({busy, rd_en, done} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle_after_done got=%b want=000", {busy, rd_en, done});
        end
        start = 1'b1;
        test_full_run(2);
    endtask

    task automatic test_mid_reset();
        logic [32:0] obs;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (585) @(negedge clk);
        // cycle 586: neuron 4, operand 49
        checks++;
        if ({rd_en, w_addr, x_addr} !== {1'b1, 11'd561, 7'd49}) begin
            failures++;
            $display("FAIL mid_reset_position got=%b/%0d/%0d want=1/561/49",
                     rd_en, w_addr, x_addr);
        end
        #2 rstn = 1'b0;
        #1;
        obs = {x_addr, w_addr, rd_en, mac_en, acc_clr, relu_en, out_addr, out_wr_en, busy, done};
        checks++;
        if (obs !== 33'd0) begin
            failures++;
            $display("FAIL mid_reset_async_clear got=%h want=0", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, rd_en, mac_en, out_wr_en, done} !== 5'b0) begin
                failures++;
                $display("FAIL mid_reset_stays_idle cycle=%0d got=%b want=00000", k,
                         {busy, rd_en, mac_en, out_wr_en, done});
            end
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, rd_en, mac_en, acc_clr, x_addr, w_addr} !== {4'b1101, 7'd0, 11'd0}) begin
            failures++;
            $display("FAIL mid_reset_restart got=%b want=%b",
                     {busy, rd_en, mac_en, acc_clr, x_addr, w_addr}, {4'b1101, 18'd0});
        end
    endtask

    // NUM_IN=4, NUM_OUT=2, DRAIN=1: 7 cycles per neuron, done on cycle 15
    task automatic test_small();
        logic [14:0] exp_v, obs_v;
        logic        e_busy, e_rd, e_mac, e_clr, e_wr, e_done, e_relu;
        logic [1:0]  e_x;
        logic [2:0]  e_w;
        logic [3:0]  e_oa;
        int          n, off;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            n       = (k - 1) / 7;
            off     = (k - 1) % 7;
            e_busy  = (k <= 15);
            e_done  = (k == 15);
            e_rd    = (k < 15) && (off < 4);
            e_mac   = (k < 15) && (off >= 1) && (off <= 4);
            e_wr    = (k < 15) && (off == 5);
            e_clr   = (k < 15) && ((off == 6) || (k == 1));
            e_relu  = RELU && e_wr;
            e_x     = e_rd ? 2'(off) : 2'd0;
            e_w     = e_rd ? 3'(n * 4 + off) : 3'd0;
            e_oa    = e_wr ? 4'(n) : 4'd0;
            exp_v   = {e_busy, e_rd, e_mac, e_clr, e_wr, e_done, e_relu, e_x, e_w, e_oa};
            obs_v   = {s_busy, s_rd_en, s_mac_en, s_acc_clr, s_out_wr_en, s_done, s_relu_en,
                       e_rd ? s_x_addr : 2'd0, e_rd ? s_w_addr : 3'd0,
                       (e_wr || e_done) ? s_out_addr : 4'd0};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL small_run cycle=%0d got=%h want=%h", k, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        @(negedge clk);
        start = 1'b1;
        test_full_run(1);
        test_back_to_back();
        test_mid_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
